button_conditioner: RTL



---
 rtl/button_conditioner.sv | 87 ++++++++
 1 files changed

// File: rtl/button_conditioner.sv
// Button/switch input conditioner: polarity normalisation, two-flop synchroniser,
// per-channel debounce, registered press/release pulses and a press-toggled latch.
module button_conditioner #(
  parameter int N_CH            = 2,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_raw,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press_pulse,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] toggled
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [N_CH-1:0] p_raw;
  logic [N_CH-1:0] s1_q, s2_q;
  logic [N_CH-1:0] db_q, db_d;
  logic [N_CH-1:0] level_q, press_q, release_q, toggled_q;

  assign p_raw = btn_raw ^ {N_CH{ACTIVE_LOW}};

  // NOTE: state updates use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the two synchroniser stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= p_raw;
      s2_q <= s1_q;
    end
  end

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    logic [CW-1:0] cnt_q, cnt_d;

    // NOTE: next-state values get defaults first so no path leaves them
    // unassigned, which would otherwise infer a latch.
    always_comb begin
      cnt_d    = '0;
      db_d[ch] = db_q[ch];
      if (s2_q[ch] != db_q[ch]) begin
        if (cnt_q == CNT_MAX) begin
          db_d[ch] = s2_q[ch];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q    <= '0;
        db_q[ch] <= 1'b0;
      end else begin
        cnt_q    <= cnt_d;
        db_q[ch] <= db_d[ch];
      end
    end
  end

  // level_q trails db_q by one cycle, so an edge of db_q is visible as db_q != level_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      toggled_q <= '0;
    end else begin
      level_q   <= db_q;
      press_q   <= db_q & ~level_q;
      release_q <= ~db_q & level_q;
      toggled_q <= toggled_q ^ (db_q & ~level_q);
    end
  end

  assign level         = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign toggled       = toggled_q;

endmodule
